user_io_spi_master: RTL and testbench
=====================================

# user_io_spi_master

SPI master that drives the MiST `user_io` command protocol from the FPGA side: it issues a command byte, up to four payload bytes and an optional read-back phase. It stands in for the board's IO controller. It is used on boards without that controller, and in simulation benches to feed `status`, `buttons` and `joystick_*` words into cores and to read back `CONF_STR`. Transfers are SPI mode 0, MSB first, under a single active-low select matching `SPI_SS_IO` (`CONF_DATA0`).

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk_sys` cycles per SCK half-period; legal range ≥ 2.

Ports (clock and reset first):
- `clk_sys` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a transfer; sampled only while idle.
- `cmd` in 8: command byte (e.g. 0x1E status, 0x01 buttons, 0x02 joystick_0, 0x14 config-string read).
- `tx_data` in 32: payload; `[31:24]` is sent first.
- `tx_len` in 3: payload byte count 0..4; values 5..7 are treated as 4.
- `rx_len` in 3: read-back byte count 0..7; MOSI is 0 during read-back.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer end.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: one-cycle pulse per received byte.
- `spi_sck` out 1: SPI clock, idles low.
- `spi_mosi` out 1: master data out (connects to `SPI_DI`).
- `spi_miso` in 1: slave data in (connects to `SPI_DO`).
- `spi_ss_n` out 1: select, active low (connects to `CONF_DATA0`).

## Operation
- Reset values: `busy`=0, `done`=0, `rx_valid`=0, `rx_data`=0x00, `spi_sck`=0, `spi_mosi`=0, `spi_ss_n`=1.
- States: IDLE, SHIFT, TAIL.
- **IDLE**
  - On `start`=1, latch `cmd`, `tx_data`, clamped `tx_len` and `rx_len`.
  - Compute total bits B = 8·(1+tx_len+rx_len), 8..96; a 7-bit counter is required.
  - Go to SHIFT.
- **SHIFT**
  - A half-period counter runs 0..CLK_DIV−1. On its wrap, `spi_sck` toggles.
  - Rising SCK: shift `spi_miso` into the rx shift register. If this is bit 7 of a read-back byte, load `rx_data` and pulse `rx_valid` on the same edge.
  - Falling SCK: drive the next MOSI bit. After the B-th falling edge, go to TAIL with `spi_mosi`=0.
- **TAIL**
  - Hold `spi_ss_n` low for CLK_DIV cycles.
  - Then set `spi_ss_n`=1, pulse `done`, clear `busy` and return to IDLE.
- Bits shifted during command and payload bytes never produce `rx_valid`.
- `start` while `busy`=1 is ignored; it is not queued.
- Inputs `cmd`, `tx_*` and `rx_len` may change freely after the start cycle.
- Reset asserted mid-transfer immediately forces all outputs to their reset values. No `done` or `rx_valid` is generated for the aborted transfer.

## Timing
- Cycle 0 is the edge that samples `start`.
- Cycle 1:
  - `busy`=1 and `spi_ss_n`=0.
  - `spi_mosi`=`cmd[7]`.
- Rising SCK edge k (k=1..B) occurs at cycle 1+(2k−1)·CLK_DIV; falling edge k at cycle 1+2k·CLK_DIV.
- Read-back byte j (j=0..rx_len−1) raises `rx_valid` at cycle 1+(2·8·(1+tx_len+j+1)−1)·CLK_DIV.
- `done`=1, `busy`=0 and `spi_ss_n`=1 at cycle 1+(2B+1)·CLK_DIV.
- A new `start` is accepted in that same cycle.
- MOSI changes only on falling SCK, or at cycle 1 for the first bit. MISO is sampled only on the edge that raises SCK.

## Test plan
- CLK_DIV=2, `cmd`=0x1E, `tx_len`=0, `rx_len`=0, start at cycle 0.
  - Required: `done` at cycle 35.
  - Exactly 8 SCK pulses with MOSI bits 0,0,0,1,1,1,1,0.
  - `spi_ss_n` low over cycles 1..34.
- `cmd`=0x1E, `tx_data`=0x00000009, `tx_len`=4.
  - A slave model captures 5 bytes: 0x1E,0x00,0x00,0x00,0x09.
  - No `rx_valid` pulse.
- `cmd`=0x14, `rx_len`=3, slave returns 0x53,0x70,0x61.
  - Three `rx_valid` pulses with `rx_data` = 0x53, 0x70, 0x61 in order.
  - MOSI is 0 throughout read-back.
- `tx_len`=6 → identical bus activity and `done` timing to `tx_len`=4.
- `start` pulsed at cycles 0 and 10 (CLK_DIV=2, 1-byte transfer) → only one transfer; a single `done` at cycle 35.
- `reset` asserted at cycle 20 of a transfer.
  - `spi_ss_n`=1, `spi_sck`=0 and `busy`=0 without waiting for a clock edge; no `done`.
  - After release, a fresh transfer completes normally.

Source files
------------

// File: rtl/user_io_spi_master_if.sv
// Signal bundle for user_io_spi_master.
// The "master" modport is the SPI master block itself: it takes transfer
// requests and MISO, and drives status, received data and the SPI pins.
// The "slave" modport is the surrounding logic that issues requests and
// plays the IO-controller side of the SPI link.
interface user_io_spi_master_if;
   logic        start;
   logic [7:0]  cmd;
   logic [31:0] tx_data;
   logic [2:0]  tx_len;
   logic [2:0]  rx_len;
   logic        busy;
   logic        done;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_ss_n;

   modport master (
      input  start, cmd, tx_data, tx_len, rx_len, spi_miso,
      output busy, done, rx_data, rx_valid, spi_sck, spi_mosi, spi_ss_n
   );

   modport slave (
      output start, cmd, tx_data, tx_len, rx_len, spi_miso,
      input  busy, done, rx_data, rx_valid, spi_sck, spi_mosi, spi_ss_n
   );
endinterface

// File: rtl/user_io_spi_master.sv
// SPI master (mode 0, MSB first) for the MiST user_io command protocol.
// One transfer = command byte, 0..4 payload bytes, 0..7 read-back bytes,
// framed by a single active-low select. Every output is registered.
module user_io_spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   user_io_spi_master_if.master  bus
);

   localparam int             CW     = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  HC_MAX = CW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_TAIL
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  hcnt_q, hcnt_d;        // clk_sys cycles within an SCK half-period
   logic [6:0]     bit_cnt_q, bit_cnt_d;  // rising SCK edges seen so far
   logic [6:0]     total_q, total_d;      // bits in this transfer, 8..96
   logic [2:0]     tx_len_q, tx_len_d;    // clamped payload byte count
   logic [38:0]    tx_sr_q, tx_sr_d;      // bits still to go out after the current MOSI bit
   logic [6:0]     rx_sr_q, rx_sr_d;      // last seven MISO bits
   logic           sck_q, sck_d;
   logic           mosi_q, mosi_d;
   logic           ss_n_q, ss_n_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           rx_valid_q, rx_valid_d;
   logic [7:0]     rx_data_q, rx_data_d;

   logic [2:0]     len_clamped;
   logic [31:0]    pay_mask;

   // Next-state and next-output logic for the whole transfer sequencer.
   // NOTE: every variable gets a default at the top so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      bit_cnt_d  = bit_cnt_q;
      total_d    = total_q;
      tx_len_d   = tx_len_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      ss_n_d     = ss_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;

      // Payload lengths above four bytes behave as four; unused payload
      // bytes are zeroed so MOSI stays low once the payload is exhausted.
      len_clamped = (bus.tx_len > 3'd4) ? 3'd4 : bus.tx_len;
      case (len_clamped)
         3'd0:    pay_mask = 32'h0000_0000;
         3'd1:    pay_mask = 32'hFF00_0000;
         3'd2:    pay_mask = 32'hFFFF_0000;
         3'd3:    pay_mask = 32'hFFFF_FF00;
         default: pay_mask = 32'hFFFF_FFFF;
      endcase

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               tx_len_d  = len_clamped;
               total_d   = {4'd1 + {1'b0, len_clamped} + {1'b0, bus.rx_len}, 3'b000};
               tx_sr_d   = {bus.cmd[6:0], bus.tx_data & pay_mask};
               mosi_d    = bus.cmd[7];
               ss_n_d    = 1'b0;
               busy_d    = 1'b1;
               sck_d     = 1'b0;
               hcnt_d    = '0;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (hcnt_q == HC_MAX) begin
               hcnt_d = '0;
               sck_d  = ~sck_q;
               if (!sck_q) begin
                  // Rising SCK: sample MISO; a byte completing past the
                  // command and payload is a read-back byte.
                  rx_sr_d   = {rx_sr_q[5:0], bus.spi_miso};
                  bit_cnt_d = bit_cnt_q + 7'd1;
                  if (bit_cnt_q[2:0] == 3'd7 && bit_cnt_q[6:3] > {1'b0, tx_len_q}) begin
                     rx_data_d  = {rx_sr_q, bus.spi_miso};
                     rx_valid_d = 1'b1;
                  end
               end else if (bit_cnt_q == total_q) begin
                  // Falling SCK after the last bit: park MOSI low and
                  // keep select asserted for one more half-period.
                  mosi_d  = 1'b0;
                  state_d = S_TAIL;
               end else begin
                  mosi_d  = tx_sr_q[38];
                  tx_sr_d = {tx_sr_q[37:0], 1'b0};
               end
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end

         S_TAIL: begin
            if (hcnt_q == HC_MAX) begin
               hcnt_d  = '0;
               ss_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset forces the bus to its idle levels at once.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         hcnt_q     <= '0;
         bit_cnt_q  <= '0;
         total_q    <= '0;
         tx_len_q   <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         ss_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         bit_cnt_q  <= bit_cnt_d;
         total_q    <= total_d;
         tx_len_q   <= tx_len_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         ss_n_q     <= ss_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.spi_sck  = sck_q;
   assign bus.spi_mosi = mosi_q;
   assign bus.spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_user_io_spi_master.sv
// Self-checking bench for user_io_spi_master with CLK_DIV=2.
// A mode-0 SPI slave model captures MOSI bytes and returns MISO bytes;
// expected bus activity and timing are derived from the transfer description.
module tb_user_io_spi_master;

   localparam int DIV = 2;

   typedef struct packed {
      logic [7:0]      cmd;
      logic [31:0]     tx_data;
      logic [2:0]      tx_len;
      logic [2:0]      rx_len;
      logic [6:0][7:0] rx_bytes;
   } xfer_t;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   user_io_spi_master_if bus ();

   user_io_spi_master #(.CLK_DIV(DIV)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   // Slave model: byte 0 of the stream goes out first, MSB first.
   logic [95:0] slave_stream = '0;
   logic [6:0]  s_idx = '0;
   logic        s_sel = 1'b0;
   logic        s_prev_sck = 1'b0;
   logic [7:0]  s_sh = '0;
   int          s_bits = 0;
   logic [7:0]  cap[$];

   assign bus.spi_miso = (s_idx < 7'd96) ? slave_stream[7'd95 - s_idx] : 1'b0;

   always @(bus.spi_ss_n or bus.spi_sck) begin
      if (bus.spi_ss_n) begin
         s_sel = 1'b0;
      end else if (!s_sel) begin
         s_sel  = 1'b1;
         s_idx  = '0;
         s_bits = 0;
         cap.delete();
      end else if (bus.spi_sck && !s_prev_sck) begin
         s_sh = {s_sh[6:0], bus.spi_mosi};
         s_bits++;
         if (s_bits % 8 == 0) cap.push_back(s_sh);
      end else if (!bus.spi_sck && s_prev_sck) begin
         s_idx = s_idx + 7'd1;
      end
      s_prev_sck = bus.spi_sck;
   end

   function automatic int clamp_len(input logic [2:0] l);
      return (l > 3'd4) ? 4 : int'(l);
   endfunction

   function automatic xfer_t rand_xfer();
      xfer_t x;
      x.cmd     = 8'($urandom);
      x.tx_data = $urandom;
      x.tx_len  = 3'($urandom_range(0, 7));
      x.rx_len  = 3'($urandom_range(0, 7));
      for (int j = 0; j < 7; j++) x.rx_bytes[j] = 8'($urandom);
      return x;
   endfunction

   task automatic set_slave(input xfer_t x);
      int tl;
      tl = clamp_len(x.tx_len);
      slave_stream = {12{8'hA5}};
      for (int j = 0; j < int'(x.rx_len); j++)
         slave_stream[95 - 8 * (1 + tl + j) -: 8] = x.rx_bytes[j];
   endtask

   task automatic load_inputs(input xfer_t x);
      bus.cmd     = x.cmd;
      bus.tx_data = x.tx_data;
      bus.tx_len  = x.tx_len;
      bus.rx_len  = x.rx_len;
   endtask

   task automatic scramble_inputs();
      bus.cmd     = 8'($urandom);
      bus.tx_data = $urandom;
      bus.tx_len  = 3'($urandom);
      bus.rx_len  = 3'($urandom);
   endtask

   // Runs one transfer and checks it against the protocol rules.
   // prestarted: start was already raised by the previous call (chain).
   // chain: raise start for nx in the done cycle and return immediately.
   // restart_cyc: raise a stray start at that cycle (0 = none).
   task automatic run_xfer(input string name, input xfer_t x, input bit prestarted,
                           input bit chain, input xfer_t nx, input int restart_cyc);
      int         tl, rl, nbits, done_exp;
      int         done_cnt, done_cyc, ss_low, mosi_bad, post_busy;
      int         rises[$];
      int         rx_cyc[$];
      logic [7:0] rx_got[$];
      logic [7:0] exp_byte;
      logic       prev_sck, prev_mosi;
      tl       = clamp_len(x.tx_len);
      rl       = int'(x.rx_len);
      nbits    = 8 * (1 + tl + rl);
      done_exp = 1 + (2 * nbits + 1) * DIV;
      done_cnt = 0; done_cyc = -1; ss_low = 0; mosi_bad = 0; post_busy = 0;
      prev_sck = 1'b0; prev_mosi = 1'b0;

      if (!prestarted) begin
         @(negedge clk_sys);
         load_inputs(x);
         set_slave(x);
         bus.start = 1'b1;
      end

      for (int c = 1; c <= done_exp + 4; c++) begin
         @(negedge clk_sys);
         if (c == 1) begin
            bus.start = 1'b0;
            checks++;
            if ({bus.busy, bus.spi_ss_n, bus.spi_mosi} !== {1'b1, 1'b0, x.cmd[7]})
               begin errors++; $display("FAIL %s cycle1 busy/ss_n/mosi got=%b want=%b", name,
                  {bus.busy, bus.spi_ss_n, bus.spi_mosi}, {1'b1, 1'b0, x.cmd[7]}); end
         end else begin
            if (bus.spi_sck && !prev_sck) rises.push_back(c);
            if (bus.spi_mosi !== prev_mosi && !(prev_sck && !bus.spi_sck)) mosi_bad++;
         end
         if (!bus.spi_ss_n) ss_low++;
         if (bus.done) begin done_cnt++; done_cyc = c; end
         if (bus.rx_valid) begin rx_got.push_back(bus.rx_data); rx_cyc.push_back(c); end
         if (c > done_exp && bus.busy) post_busy++;
         if (c == done_exp) begin
            checks++;
            if ({bus.busy, bus.spi_ss_n, bus.spi_sck} !== 3'b010)
               begin errors++; $display("FAIL %s end busy/ss_n/sck got=%b want=010", name,
                  {bus.busy, bus.spi_ss_n, bus.spi_sck}); end
         end
         prev_sck  = bus.spi_sck;
         prev_mosi = bus.spi_mosi;
         if (c == restart_cyc) bus.start = 1'b1;
         else if (c == restart_cyc + 1) bus.start = 1'b0;
         if (chain && c == done_exp) begin
            load_inputs(nx);
            set_slave(nx);
            bus.start = 1'b1;
            break;
         end
         scramble_inputs();
      end

      checks++;
      if (done_cnt !== 1 || done_cyc !== done_exp)
         begin errors++; $display("FAIL %s done pulses=%0d at cycle %0d want 1 at %0d", name,
            done_cnt, done_cyc, done_exp); end
      checks++;
      if (ss_low !== done_exp - 1)
         begin errors++; $display("FAIL %s ss_n low cycles got=%0d want=%0d", name, ss_low, done_exp - 1); end
      checks++;
      if (post_busy !== 0)
         begin errors++; $display("FAIL %s busy after done got=%0d cycles want=0", name, post_busy); end
      checks++;
      if (mosi_bad !== 0)
         begin errors++; $display("FAIL %s mosi changed off falling sck %0d times want 0", name, mosi_bad); end
      checks++;
      if (rises.size() !== nbits)
         begin errors++; $display("FAIL %s sck pulses got=%0d want=%0d", name, rises.size(), nbits); end
      for (int k = 0; k < rises.size() && k < nbits; k++) begin
         checks++;
         if (rises[k] !== 1 + (2 * (k + 1) - 1) * DIV)
            begin errors++; $display("FAIL %s sck rise %0d at cycle %0d want %0d", name, k + 1,
               rises[k], 1 + (2 * (k + 1) - 1) * DIV); end
      end
      checks++;
      if (cap.size() !== 1 + tl + rl)
         begin errors++; $display("FAIL %s mosi bytes got=%0d want=%0d", name, cap.size(), 1 + tl + rl); end
      for (int i = 0; i < cap.size() && i < 1 + tl + rl; i++) begin
         if (i == 0)       exp_byte = x.cmd;
         else if (i <= tl) exp_byte = x.tx_data[31 - 8 * (i - 1) -: 8];
         else              exp_byte = 8'h00;
         checks++;
         if (cap[i] !== exp_byte)
            begin errors++; $display("FAIL %s mosi byte %0d got=%h want=%h", name, i, cap[i], exp_byte); end
      end
      checks++;
      if (rx_got.size() !== rl)
         begin errors++; $display("FAIL %s rx_valid pulses got=%0d want=%0d", name, rx_got.size(), rl); end
      for (int j = 0; j < rx_got.size() && j < rl; j++) begin
         checks++;
         if (rx_got[j] !== x.rx_bytes[j] || rx_cyc[j] !== 1 + (16 * (1 + tl + j + 1) - 1) * DIV)
            begin errors++; $display("FAIL %s rx byte %0d got=%h@%0d want=%h@%0d", name, j, rx_got[j],
               rx_cyc[j], x.rx_bytes[j], 1 + (16 * (1 + tl + j + 1) - 1) * DIV); end
      end
   endtask

   xfer_t none_x;

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      load_inputs(none_x);
      repeat (2) @(negedge clk_sys);
      checks++;
      if ({bus.busy, bus.done, bus.rx_valid, bus.spi_sck, bus.spi_mosi, bus.spi_ss_n, bus.rx_data}
          !== {5'b00000, 1'b1, 8'h00})
         begin errors++; $display("FAIL reset_values got=%b want=%b",
            {bus.busy, bus.done, bus.rx_valid, bus.spi_sck, bus.spi_mosi, bus.spi_ss_n, bus.rx_data},
            {5'b00000, 1'b1, 8'h00}); end
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic test_cmd_only();
      xfer_t x = '0;
      x.cmd = 8'h1E;
      run_xfer("cmd_only", x, 1'b0, 1'b0, none_x, 0);
   endtask

   task automatic test_payload();
      xfer_t x = '0;
      x.cmd = 8'h1E; x.tx_data = 32'h0000_0009; x.tx_len = 3'd4;
      run_xfer("payload4", x, 1'b0, 1'b0, none_x, 0);
   endtask

   task automatic test_readback();
      xfer_t x = '0;
      x.cmd = 8'h14; x.rx_len = 3'd3;
      x.rx_bytes[0] = 8'h53; x.rx_bytes[1] = 8'h70; x.rx_bytes[2] = 8'h61;
      run_xfer("readback", x, 1'b0, 1'b0, none_x, 0);
   endtask

   task automatic test_len_clamp();
      xfer_t x = rand_xfer();
      x.tx_len = 3'd6; x.rx_len = 3'd1;
      run_xfer("clamp6", x, 1'b0, 1'b0, none_x, 0);
      x.tx_len = 3'd7;
      run_xfer("clamp7", x, 1'b0, 1'b0, none_x, 0);
   endtask

   task automatic test_start_ignored();
      xfer_t x = '0;
      x.cmd = 8'h01;
      run_xfer("start_ignored", x, 1'b0, 1'b0, none_x, 10);
   endtask

   task automatic test_back_to_back();
      xfer_t a, b;
      a = rand_xfer();
      b = rand_xfer();
      run_xfer("b2b_first", a, 1'b0, 1'b1, b, 0);
      run_xfer("b2b_second", b, 1'b1, 1'b0, none_x, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) run_xfer($sformatf("random%0d", n), rand_xfer(), 1'b0, 1'b0, none_x, 0);
   endtask

   task automatic test_reset_abort();
      xfer_t x = '0;
      int    done_cnt, rxv_cnt, ss_low;
      x.cmd = 8'h14; x.rx_len = 3'd2;
      x.rx_bytes[0] = 8'h3C; x.rx_bytes[1] = 8'hC3;
      @(negedge clk_sys);
      load_inputs(x);
      set_slave(x);
      bus.start = 1'b1;
      @(negedge clk_sys);
      bus.start = 1'b0;
      repeat (19) @(negedge clk_sys);
      checks++;
      if (bus.busy !== 1'b1)
         begin errors++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.rx_valid, bus.spi_sck, bus.spi_mosi, bus.spi_ss_n, bus.rx_data}
          !== {5'b00000, 1'b1, 8'h00})
         begin errors++; $display("FAIL abort_async_reset got=%b want=%b",
            {bus.busy, bus.done, bus.rx_valid, bus.spi_sck, bus.spi_mosi, bus.spi_ss_n, bus.rx_data},
            {5'b00000, 1'b1, 8'h00}); end
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      done_cnt = 0; rxv_cnt = 0; ss_low = 0;
      repeat (80) begin
         @(negedge clk_sys);
         if (bus.done) done_cnt++;
         if (bus.rx_valid) rxv_cnt++;
         if (!bus.spi_ss_n) ss_low++;
      end
      checks++;
      if ({done_cnt, rxv_cnt, ss_low} !== {32'd0, 32'd0, 32'd0})
         begin errors++; $display("FAIL abort_quiet done=%0d rx_valid=%0d ss_low=%0d want 0/0/0",
            done_cnt, rxv_cnt, ss_low); end
      run_xfer("after_abort", x, 1'b0, 1'b0, none_x, 0);
   endtask

   initial begin
      none_x    = '0;
      bus.start = 1'b0;
      test_reset();
      test_cmd_only();
      test_payload();
      test_readback();
      test_reset_abort();
      test_len_clamp();
      test_start_ignored();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
